// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between pipeline writeback and a long-latency unit,
// and tracks in-flight long-latency destinations to stall decode on RAW/WAW hazards.
module regfile_wb_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_wa,
    input  logic [DATA_W-1:0] pipe_wd,
    output logic              pipe_hold,
    input  logic              ll_issue,
    input  logic [ADDR_W-1:0] ll_issue_wa,
    input  logic              ll_valid,
    input  logic [ADDR_W-1:0] ll_wa,
    input  logic [DATA_W-1:0] ll_wd,
    output logic              ll_ready,
    input  logic              chk_re1,
    input  logic              chk_re2,
    input  logic [ADDR_W-1:0] chk_ra1,
    input  logic [ADDR_W-1:0] chk_ra2,
    input  logic              chk_we,
    input  logic [ADDR_W-1:0] chk_wa,
    output logic              hazard_stall,
    output logic              issue_err,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd
);
    logic [NUM_REGS-1:0] pending_q, pending_d, set_v, clr_v;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                issue_err_q, issue_err_d;
    logic                grant_ll, commit;

    always_comb begin
        pipe_hold    = !cpu_rst && (wait_cnt_q >= 4'(STARVE_LIMIT));
        grant_ll     = pipe_hold || !pipe_we;
        ll_ready     = !cpu_rst && grant_ll;
        rf_we        = !cpu_rst && (grant_ll ? ll_valid : 1'b1);
        rf_wa        = !rf_we ? '0 : grant_ll ? ll_wa : pipe_wa;
        rf_wd        = !rf_we ? '0 : grant_ll ? ll_wd : pipe_wd;
        commit       = ll_valid && ll_ready;
        // A register committing this cycle still stalls; the bypass supplies it next cycle.
        hazard_stall = !cpu_rst && ((chk_re1 && pending_q[chk_ra1]) ||
                                    (chk_re2 && pending_q[chk_ra2]) ||
                                    (chk_we  && pending_q[chk_wa]));
        issue_err    = issue_err_q && !cpu_rst;
        wait_cnt_d   = (!ll_valid || commit) ? 4'd0 :
                       (wait_cnt_q == 4'hf) ? wait_cnt_q : wait_cnt_q + 4'd1;
        set_v        = (ll_issue && ll_issue_wa != '0) ? NUM_REGS'(1) << ll_issue_wa : '0;
        clr_v        = commit ? NUM_REGS'(1) << ll_wa : '0;
        pending_d    = (pending_q & ~clr_v) | set_v;
        issue_err_d  = issue_err_q || (ll_issue && pending_q[ll_issue_wa] &&
                                       !(commit && ll_wa == ll_issue_wa));
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            pending_q   <= '0;
            wait_cnt_q  <= '0;
            issue_err_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            wait_cnt_q  <= wait_cnt_d;
            issue_err_q <= issue_err_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for the regfile writeback arbiter.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we, ll_issue, ll_valid, chk_re1, chk_re2, chk_we;
    logic [4:0]  pipe_wa, ll_issue_wa, ll_wa, chk_ra1, chk_ra2, chk_wa;
    logic [31:0] pipe_wd, ll_wd;
    logic        pipe_hold, ll_ready, hazard_stall, issue_err, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    int          checks = 0;
    int          failures = 0;
    logic        e_err = 1'b0;

    typedef struct {
        string       tag;
        logic [41:0] v;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .cpu_clk_50M(clk), .cpu_rst(rst),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_hold(pipe_hold),
        .ll_issue(ll_issue), .ll_issue_wa(ll_issue_wa),
        .ll_valid(ll_valid), .ll_wa(ll_wa), .ll_wd(ll_wd), .ll_ready(ll_ready),
        .chk_re1(chk_re1), .chk_re2(chk_re2), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2),
        .chk_we(chk_we), .chk_wa(chk_wa), .hazard_stall(hazard_stall), .issue_err(issue_err),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, 64'({rf_we, rf_wa, rf_wd, ll_ready, pipe_hold, hazard_stall, issue_err}),
                  64'(e.v));
        end
    end

    task automatic expect_out(input string tag, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic rdy, input logic hold,
                              input logic stall);
        exp_t e;
        e.tag = tag;
        e.v   = {we, wa, wd, rdy, hold, stall, e_err};
        exp_q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
        ll_issue = 0; ll_issue_wa = 0; ll_valid = 0; ll_wa = 0; ll_wd = 0;
        chk_re1 = 0; chk_re2 = 0; chk_we = 0; chk_ra1 = 0; chk_ra2 = 0; chk_wa = 0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        pipe_we = 1; pipe_wa = a; pipe_wd = d;
    endtask

    task automatic llv(input logic [4:0] a, input logic [31:0] d);
        ll_valid = 1; ll_wa = a; ll_wd = d;
    endtask

    task automatic issue(input logic [4:0] a);
        ll_issue = 1; ll_issue_wa = a;
    endtask

    initial begin
        next();
        next();
        pipe(3, 32'h11); llv(4, 32'h44); chk_re1 = 1;
        expect_out("rst_forced", 0, 0, 0, 0, 0, 0);
        next(); rst = 0;
        expect_out("idle", 0, 0, 0, 1, 0, 0);
        next(); pipe(3, 32'h11);
        expect_out("pipe_wr", 1, 3, 32'h11, 0, 0, 0);
        next(); issue(5);
        expect_out("issue5", 0, 0, 0, 1, 0, 0);
        next(); chk_re1 = 1; chk_ra1 = 5;
        expect_out("raw5", 0, 0, 0, 1, 0, 1);
        next(); llv(5, 32'hABCD); chk_re1 = 1; chk_ra1 = 5;
        expect_out("commit5", 1, 5, 32'hABCD, 1, 0, 1);
        next(); chk_re1 = 1; chk_ra1 = 5;
        expect_out("clear5", 0, 0, 0, 1, 0, 0);
        next(); issue(6);
        expect_out("issue6", 0, 0, 0, 1, 0, 0);
        next(); chk_re2 = 1; chk_ra2 = 6;
        expect_out("raw6_re2", 0, 0, 0, 1, 0, 1);
        next(); chk_we = 1; chk_wa = 6;
        expect_out("waw6", 0, 0, 0, 1, 0, 1);
        next(); chk_ra1 = 6; chk_we = 1; chk_wa = 4;
        expect_out("no_en6", 0, 0, 0, 1, 0, 0);
        next(); llv(6, 32'h66);
        expect_out("commit6", 1, 6, 32'h66, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            next(); pipe(2, 32'h22); llv(8, 32'h88);
            expect_out($sformatf("starve%0d", i), 1, 2, 32'h22, 0, 0, 0);
        end
        next(); pipe(2, 32'h22); llv(8, 32'h88);
        expect_out("forced_ll", 1, 8, 32'h88, 1, 1, 0);
        next(); pipe(2, 32'h22); llv(8, 32'h88);
        expect_out("pipe_back", 1, 2, 32'h22, 0, 0, 0);
        next();
        expect_out("idle2", 0, 0, 0, 1, 0, 0);
        next(); issue(7);
        expect_out("issue7", 0, 0, 0, 1, 0, 0);
        next(); issue(7); llv(7, 32'h77);
        expect_out("reissue7_commit", 1, 7, 32'h77, 1, 0, 0);
        next(); issue(7); chk_re1 = 1; chk_ra1 = 7;
        expect_out("set_wins7", 0, 0, 0, 1, 0, 1);
        next(); e_err = 1;
        expect_out("issue_err", 0, 0, 0, 1, 0, 0);
        next();
        expect_out("err_sticky", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            next(); pipe(2, 32'h22); llv(8, 32'h88);
            expect_out($sformatf("pre_gap%0d", i), 1, 2, 32'h22, 0, 0, 0);
        end
        next(); pipe(2, 32'h22);
        expect_out("gap", 1, 2, 32'h22, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            next(); pipe(2, 32'h22); llv(8, 32'h88);
            expect_out($sformatf("post_gap%0d", i), 1, 2, 32'h22, 0, 0, 0);
        end
        next(); pipe(2, 32'h22); llv(8, 32'h88);
        expect_out("gap_forced", 1, 8, 32'h88, 1, 1, 0);
        next(); issue(0);
        expect_out("issue0", 0, 0, 0, 1, 0, 0);
        next(); pipe(0, 32'h5); chk_re1 = 1; chk_ra1 = 0;
        expect_out("wr0_nostall", 1, 0, 32'h5, 0, 0, 0);
        next(); issue(9);
        expect_out("issue9", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            next(); pipe(2, 32'h22); llv(10, 32'hAA);
            expect_out($sformatf("pre_rst%0d", i), 1, 2, 32'h22, 0, 0, 0);
        end
        next(); rst = 1; pipe(2, 32'h22); llv(10, 32'hAA); chk_re1 = 1; chk_ra1 = 9;
        e_err = 0;
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            next(); rst = 0; pipe(2, 32'h22); llv(10, 32'hAA); chk_re1 = 1; chk_ra1 = 9;
            expect_out($sformatf("post_rst%0d", i), 1, 2, 32'h22, 0, 0, 0);
        end
        next(); pipe(2, 32'h22); llv(10, 32'hAA);
        expect_out("post_rst_forced", 1, 10, 32'hAA, 1, 1, 0);
        next(); pipe(2, 32'h22);
        expect_out("final_pipe", 1, 2, 32'h22, 0, 0, 0);
        next();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
